// File: rtl/cpu_control_pkg.sv
// Shared definitions for the CPU run/debug controller.
//   - Core widths (program counter, instruction word, opcode field)
//   - Default program depth and executed-cycle counter width
//   - Run-state encoding, which is visible on the controller's state port
//   - Opcode extraction helpers
package cpu_control_pkg;

  localparam int PC_WIDTH                  = 8;
  localparam int INSTRUCTION_WIDTH         = 16;
  localparam int OPCODE_WIDTH              = 4;
  localparam int DEFAULT_PROGRAM_DEPTH     = 256;
  localparam int DEFAULT_CYCLE_COUNT_WIDTH = 16;

  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_CPU_RESET = 3'd2,
    ST_RUN       = 3'd3,
    ST_HALTED    = 3'd4,
    ST_STEP      = 3'd5
  } run_state_t;

  // The opcode occupies the top bits of the instruction word.
  function automatic logic [OPCODE_WIDTH-1:0] opcode_of(
    input logic [INSTRUCTION_WIDTH-1:0] instr
  );
    return instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  endfunction

  function automatic logic is_halt_opcode(
    input logic [INSTRUCTION_WIDTH-1:0] instr
  );
    return opcode_of(instr) == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/program_loader.sv
// Instruction-memory loader.
// Accepts a valid/ready word stream and turns each accepted word into a
// one-cycle write on a registered memory write port, at consecutive
// addresses starting from 0.
//   clock, reset    system clock, synchronous active-high reset
//   begin_load      pulse: start a new load at address 0
//   load_valid      stream word valid
//   load_data       stream word
//   load_last       final word of the program (qualified by load_valid)
//   load_ready      loader is accepting words
//   write_enable    memory write strobe, one cycle after each handshake
//   write_address   memory write address
//   write_data      memory write data
//   done            high in the cycle of the final handshake
module program_loader
  import cpu_control_pkg::*;
#(
  parameter int PROGRAM_DEPTH = DEFAULT_PROGRAM_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         begin_load,
  input  logic                         load_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] load_data,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic                         write_enable,
  output logic [PC_WIDTH-1:0]          write_address,
  output logic [INSTRUCTION_WIDTH-1:0] write_data,
  output logic                         done
);

  localparam logic [PC_WIDTH-1:0] LAST_ADDRESS = PC_WIDTH'(PROGRAM_DEPTH - 1);

  logic                active;
  logic [PC_WIDTH-1:0] next_address;
  logic                accept;

  assign load_ready = active;
  assign accept     = active & load_valid;
  // The load ends on an explicit last word or when the memory is full, so
  // the address counter never has to wrap.
  assign done       = accept & (load_last | (next_address == LAST_ADDRESS));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      active        <= 1'b0;
      next_address  <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      write_enable <= accept;
      if (begin_load) begin
        active       <= 1'b1;
        next_address <= '0;
      end else if (accept) begin
        write_address <= next_address;
        write_data    <= load_data;
        if (done) begin
          active <= 1'b0;
        end else begin
          next_address <= next_address + PC_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/debug sequencer for the CPU core.
// Owns the core's reset and clock enable, loads instruction memory while the
// core is held in reset, and starts, halts, resumes and single-steps it.
// Halts come from a HALT opcode, an external request or a PC breakpoint.
//   clock, reset             system clock, synchronous active-high reset
//   loadStart                pulse: begin program load (IDLE only)
//   loadValid/loadData/
//   loadLast/loadReady       program load stream
//   start                    pulse: reset core and run from pc 0 (IDLE/HALTED)
//   resume                   pulse: continue from current pc (HALTED)
//   stepRequest              pulse: execute one cycle (HALTED)
//   haltRequest              level: halt at next opportunity
//   breakpointEnable/Address PC breakpoint
//   pc, instruction          current core program counter and instruction
//   imemWrite*               instruction memory write port
//   cpuReset, cpuEnable      core reset and clock enable
//   halted                   state is HALTED
//   cycleCount               saturating count of cycles with cpuEnable high
//   state                    current run state (run_state_t encoding)
module cpu_run_controller
  import cpu_control_pkg::*;
#(
  parameter int PROGRAM_DEPTH     = DEFAULT_PROGRAM_DEPTH,
  parameter int CYCLE_COUNT_WIDTH = DEFAULT_CYCLE_COUNT_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         loadStart,
  input  logic                         loadValid,
  input  logic [INSTRUCTION_WIDTH-1:0] loadData,
  input  logic                         loadLast,
  output logic                         loadReady,
  input  logic                         start,
  input  logic                         resume,
  input  logic                         stepRequest,
  input  logic                         haltRequest,
  input  logic                         breakpointEnable,
  input  logic [PC_WIDTH-1:0]          breakpointAddress,
  input  logic [PC_WIDTH-1:0]          pc,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         imemWriteEnable,
  output logic [PC_WIDTH-1:0]          imemWriteAddress,
  output logic [INSTRUCTION_WIDTH-1:0] imemWriteData,
  output logic                         cpuReset,
  output logic                         cpuEnable,
  output logic                         halted,
  output logic [CYCLE_COUNT_WIDTH-1:0] cycleCount,
  output logic [2:0]                   state
);

  run_state_t                   state_q;
  run_state_t                   state_next;
  logic                         skip_bp;
  logic                         skip_bp_next;
  logic                         halt_opcode;
  logic                         breakpoint_hit;
  logic                         halt_cond;
  logic                         begin_load;
  logic                         load_done;
  logic                         cpu_reset_q;
  logic                         halted_q;
  logic [CYCLE_COUNT_WIDTH-1:0] cycle_count_q;

  assign begin_load = (state_q == ST_IDLE) && loadStart;

  program_loader #(
    .PROGRAM_DEPTH(PROGRAM_DEPTH)
  ) u_loader (
    .clock        (clock),
    .reset        (reset),
    .begin_load   (begin_load),
    .load_valid   (loadValid),
    .load_data    (loadData),
    .load_last    (loadLast),
    .load_ready   (loadReady),
    .write_enable (imemWriteEnable),
    .write_address(imemWriteAddress),
    .write_data   (imemWriteData),
    .done         (load_done)
  );

  // skip_bp masks the breakpoint for the first cycle after resume, so the
  // core can execute the instruction it stopped on.
  assign halt_opcode    = is_halt_opcode(instruction);
  assign breakpoint_hit = breakpointEnable && (pc == breakpointAddress) && !skip_bp;
  assign halt_cond      = haltRequest || halt_opcode || breakpoint_hit;

  // cpuEnable must drop in the same cycle the halt condition appears so the
  // halting instruction is never executed; it is therefore combinational.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next   = state_q;
    skip_bp_next = 1'b0;
    cpuEnable    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (loadStart) begin
          state_next = ST_LOAD;
        end else if (start) begin
          state_next = ST_CPU_RESET;
        end
      end
      ST_LOAD: begin
        if (load_done) begin
          state_next = ST_IDLE;
        end
      end
      ST_CPU_RESET: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        cpuEnable = !halt_cond;
        if (halt_cond) begin
          state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (start) begin
          state_next = ST_CPU_RESET;
        end else if (resume) begin
          state_next   = ST_RUN;
          skip_bp_next = 1'b1;
        end else if (stepRequest) begin
          state_next = ST_STEP;
        end
      end
      ST_STEP: begin
        // A step ignores haltRequest and the breakpoint; only a HALT opcode
        // stops it from executing.
        cpuEnable  = !halt_opcode;
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // cpuReset and halted are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      skip_bp       <= 1'b0;
      cpu_reset_q   <= 1'b1;
      halted_q      <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q     <= state_next;
      skip_bp     <= skip_bp_next;
      cpu_reset_q <= (state_next == ST_IDLE) || (state_next == ST_LOAD) ||
                     (state_next == ST_CPU_RESET);
      halted_q    <= (state_next == ST_HALTED);
      if (state_q == ST_CPU_RESET) begin
        cycle_count_q <= '0;
      end else if (cpuEnable && (cycle_count_q != '1)) begin
        cycle_count_q <= cycle_count_q + CYCLE_COUNT_WIDTH'(1);
      end
    end
  end

  assign cpuReset   = cpu_reset_q;
  assign halted     = halted_q;
  assign cycleCount = cycle_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller. A tiny core model (pc register and
// instruction memory fed by the controller's write port) closes the loop.
// The counter is built 4 bits wide so saturation is reachable quickly.
module tb_cpu_run_controller;
  import cpu_control_pkg::*;

  localparam int CW = 4;

  logic                         clock = 1'b0;
  logic                         reset = 1'b1;
  logic                         loadStart = 1'b0;
  logic                         loadValid = 1'b0;
  logic [INSTRUCTION_WIDTH-1:0] loadData = '0;
  logic                         loadLast = 1'b0;
  logic                         loadReady;
  logic                         start = 1'b0;
  logic                         resume = 1'b0;
  logic                         stepRequest = 1'b0;
  logic                         haltRequest = 1'b0;
  logic                         breakpointEnable = 1'b0;
  logic [PC_WIDTH-1:0]          breakpointAddress = '0;
  logic [PC_WIDTH-1:0]          pc = '0;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         imemWriteEnable;
  logic [PC_WIDTH-1:0]          imemWriteAddress;
  logic [INSTRUCTION_WIDTH-1:0] imemWriteData;
  logic                         cpuReset;
  logic                         cpuEnable;
  logic                         halted;
  logic [CW-1:0]                cycleCount;
  logic [2:0]                   state;

  cpu_run_controller #(
    .PROGRAM_DEPTH    (256),
    .CYCLE_COUNT_WIDTH(CW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .loadStart        (loadStart),
    .loadValid        (loadValid),
    .loadData         (loadData),
    .loadLast         (loadLast),
    .loadReady        (loadReady),
    .start            (start),
    .resume           (resume),
    .stepRequest      (stepRequest),
    .haltRequest      (haltRequest),
    .breakpointEnable (breakpointEnable),
    .breakpointAddress(breakpointAddress),
    .pc               (pc),
    .instruction      (instruction),
    .imemWriteEnable  (imemWriteEnable),
    .imemWriteAddress (imemWriteAddress),
    .imemWriteData    (imemWriteData),
    .cpuReset         (cpuReset),
    .cpuEnable        (cpuEnable),
    .halted           (halted),
    .cycleCount       (cycleCount),
    .state            (state)
  );

  always #5 clock = ~clock;

  // Core model: instruction memory written by the controller, pc advancing
  // on every enabled cycle and cleared by cpuReset.
  logic [INSTRUCTION_WIDTH-1:0] imem [256];
  assign instruction = imem[pc];

  always @(posedge clock) begin
    if (imemWriteEnable) imem[imemWriteAddress] <= imemWriteData;
    if (cpuReset) pc <= '0;
    else if (cpuEnable) pc <= pc + 8'd1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic clear_pulses();
    loadStart   = 1'b0;
    loadValid   = 1'b0;
    loadLast    = 1'b0;
    loadData    = '0;
    start       = 1'b0;
    resume      = 1'b0;
    stepRequest = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    clear_pulses();
  endtask

  // Sample one cycle mid-period, check the run-control outputs, advance.
  task automatic cyc(input string tag, input int est, input int een, input int epc, input int ecnt);
    @(negedge clock);
    check({tag, " state"}, state, est);
    check({tag, " cpuEnable"}, cpuEnable, een);
    check({tag, " pc"}, pc, epc);
    check({tag, " cycleCount"}, cycleCount, ecnt);
    check({tag, " halted"}, halted, (est == 4) ? 1 : 0);
    check({tag, " cpuReset"}, cpuReset, (est <= 2) ? 1 : 0);
    next_cycle();
  endtask

  typedef struct {
    logic        ls, lv, ll, st, rs, sr;
    logic [15:0] ld;
    logic [2:0]  es;
    logic        erdy, ewe, ecr, een, eh;
    logic [7:0]  ea;
    logic [15:0] ed;
    logic [3:0]  ec;
    logic [7:0]  ep;
  } vec_t;

  function automatic vec_t mk(input int ls, input int lv, input int ld, input int ll,
                              input int st, input int rs, input int sr,
                              input int es, input int erdy, input int ewe, input int ea,
                              input int ed, input int ecr, input int een, input int eh,
                              input int ec, input int ep);
    vec_t v;
    v.ls = ls[0]; v.lv = lv[0]; v.ld = ld[15:0]; v.ll = ll[0];
    v.st = st[0]; v.rs = rs[0]; v.sr = sr[0];
    v.es = es[2:0]; v.erdy = erdy[0]; v.ewe = ewe[0]; v.ea = ea[7:0];
    v.ed = ed[15:0]; v.ecr = ecr[0]; v.een = een[0]; v.eh = eh[0];
    v.ec = ec[3:0]; v.ep = ep[7:0];
    return v;
  endfunction

  vec_t        vecs [14];
  logic [15:0] prog [4];

  initial begin
    prog[0] = 16'h1001; prog[1] = 16'h2002; prog[2] = 16'h3003; prog[3] = 16'hF000;

    //              ls lv ld       ll st rs sr  st rdy we a  data     crst en h cnt pc
    vecs[0]  = mk(0, 0, 0,       0, 0, 1, 1,  0, 0, 0, 0, 0,       1, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0,       0, 1, 0, 0,  0, 0, 0, 0, 0,       1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 'h1001,  0, 0, 0, 0,  1, 1, 0, 0, 0,       1, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 'h2002,  0, 1, 0, 0,  1, 1, 1, 0, 'h1001,  1, 0, 0, 0, 0);
    vecs[4]  = mk(0, 1, 'h3003,  0, 0, 0, 0,  1, 1, 1, 1, 'h2002,  1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 'hF000,  1, 0, 0, 0,  1, 1, 1, 2, 'h3003,  1, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0,       0, 0, 0, 0,  0, 0, 1, 3, 'hF000,  1, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0,       0, 1, 0, 0,  0, 0, 0, 3, 'hF000,  1, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0,       0, 0, 0, 0,  2, 0, 0, 3, 'hF000,  1, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0,       0, 0, 1, 0,  3, 0, 0, 3, 'hF000,  0, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 0,       0, 0, 0, 1,  3, 0, 0, 3, 'hF000,  0, 1, 0, 1, 1);
    vecs[11] = mk(0, 0, 0,       0, 0, 0, 0,  3, 0, 0, 3, 'hF000,  0, 1, 0, 2, 2);
    vecs[12] = mk(0, 0, 0,       0, 0, 0, 0,  3, 0, 0, 3, 'hF000,  0, 0, 0, 3, 3);
    vecs[13] = mk(0, 0, 0,       0, 0, 0, 0,  4, 0, 0, 3, 'hF000,  0, 0, 1, 3, 3);

    // Reset state.
    reset = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clock);
    check("rst state", state, 0);
    check("rst cpuReset", cpuReset, 1);
    check("rst cpuEnable", cpuEnable, 0);
    check("rst loadReady", loadReady, 0);
    check("rst we", imemWriteEnable, 0);
    check("rst addr", imemWriteAddress, 0);
    check("rst data", imemWriteData, 0);
    check("rst cycleCount", cycleCount, 0);
    check("rst halted", halted, 0);
    reset = 1'b0;
    next_cycle();

    // Table: ignored commands in IDLE, loadStart beats start, load with
    // start ignored in LOAD, run to the HALT at pc 3.
    for (int i = 0; i < 14; i++) begin
      loadStart = vecs[i].ls; loadValid = vecs[i].lv; loadData = vecs[i].ld;
      loadLast = vecs[i].ll; start = vecs[i].st; resume = vecs[i].rs;
      stepRequest = vecs[i].sr;
      @(negedge clock);
      check($sformatf("row%0d state", i), state, vecs[i].es);
      check($sformatf("row%0d loadReady", i), loadReady, vecs[i].erdy);
      check($sformatf("row%0d we", i), imemWriteEnable, vecs[i].ewe);
      check($sformatf("row%0d addr", i), imemWriteAddress, vecs[i].ea);
      check($sformatf("row%0d data", i), imemWriteData, vecs[i].ed);
      check($sformatf("row%0d cpuReset", i), cpuReset, vecs[i].ecr);
      check($sformatf("row%0d cpuEnable", i), cpuEnable, vecs[i].een);
      check($sformatf("row%0d halted", i), halted, vecs[i].eh);
      check($sformatf("row%0d cycleCount", i), cycleCount, vecs[i].ec);
      check($sformatf("row%0d pc", i), pc, vecs[i].ep);
      next_cycle();
    end

    // Breakpoint at pc 2, then resume past it to the HALT at pc 3.
    breakpointEnable = 1'b1; breakpointAddress = 8'd2;
    start = 1'b1;
    cyc("bp cmd", 4, 0, 3, 3);
    cyc("bp creset", 2, 0, 3, 3);
    cyc("bp run0", 3, 1, 0, 0);
    cyc("bp run1", 3, 1, 1, 1);
    cyc("bp hit", 3, 0, 2, 2);
    cyc("bp halted", 4, 0, 2, 2);
    resume = 1'b1;
    cyc("res cmd", 4, 0, 2, 2);
    cyc("res skip", 3, 1, 2, 2);
    cyc("res halt", 3, 0, 3, 3);
    cyc("res halted", 4, 0, 3, 3);

    // Halt at pc 1 via breakpoint, then single-step twice and once more
    // onto the HALT opcode.
    breakpointAddress = 8'd1;
    start = 1'b1;
    cyc("st cmd", 4, 0, 3, 3);
    cyc("st creset", 2, 0, 3, 3);
    cyc("st run0", 3, 1, 0, 0);
    cyc("st bp", 3, 0, 1, 1);
    cyc("st halted", 4, 0, 1, 1);
    stepRequest = 1'b1;
    cyc("step1 cmd", 4, 0, 1, 1);
    cyc("step1", 5, 1, 1, 1);
    cyc("step1 back", 4, 0, 2, 2);
    stepRequest = 1'b1;
    cyc("step2 cmd", 4, 0, 2, 2);
    haltRequest = 1'b1;
    cyc("step2", 5, 1, 2, 2);
    haltRequest = 1'b0;
    cyc("step2 back", 4, 0, 3, 3);
    stepRequest = 1'b1;
    cyc("step3 cmd", 4, 0, 3, 3);
    cyc("step3 halt", 5, 0, 3, 3);
    cyc("step3 back", 4, 0, 3, 3);
    breakpointEnable = 1'b0;

    // Reset aborts from HALTED, then reset held 3 cycles mid-LOAD.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check("abort state", state, 0);
    check("abort cpuReset", cpuReset, 1);
    next_cycle();
    loadStart = 1'b1;
    next_cycle();
    loadValid = 1'b1; loadData = prog[0];
    next_cycle();
    loadValid = 1'b1; loadData = prog[1];
    @(negedge clock);
    check("ml w0 we", imemWriteEnable, 1);
    check("ml w0 addr", imemWriteAddress, 0);
    next_cycle();
    reset = 1'b1; loadValid = 1'b1; loadData = prog[2];
    @(negedge clock);
    check("ml w1 addr", imemWriteAddress, 1);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      reset = (k < 2); loadValid = 1'b1; loadData = prog[2];
      @(negedge clock);
      check($sformatf("ml rst%0d state", k), state, 0);
      check($sformatf("ml rst%0d we", k), imemWriteEnable, 0);
      check($sformatf("ml rst%0d addr", k), imemWriteAddress, 0);
      check($sformatf("ml rst%0d loadReady", k), loadReady, 0);
      check($sformatf("ml rst%0d cpuReset", k), cpuReset, 1);
      next_cycle();
    end
    reset = 1'b0;
    @(negedge clock);
    check("ml after we", imemWriteEnable, 0);
    check("ml after addr", imemWriteAddress, 0);
    check("ml after state", state, 0);
    next_cycle();

    // Load with loadValid toggling every other cycle.
    loadStart = 1'b1;
    next_cycle();
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        loadValid = j[0];
        loadData  = prog[j/2];
        loadLast  = (j == 7);
      end
      @(negedge clock);
      check($sformatf("tg%0d state", j), state, (j < 8) ? 1 : 0);
      check($sformatf("tg%0d loadReady", j), loadReady, (j < 8) ? 1 : 0);
      check($sformatf("tg%0d we", j), imemWriteEnable, (j >= 2 && !j[0]) ? 1 : 0);
      if (j >= 2 && !j[0]) begin
        check($sformatf("tg%0d addr", j), imemWriteAddress, (j - 2) / 2);
        check($sformatf("tg%0d data", j), imemWriteData, prog[(j-2)/2]);
      end
      next_cycle();
    end

    // Full-depth load with no loadLast: ends after address 255.
    loadStart = 1'b1;
    next_cycle();
    for (int i = 0; i < 256; i++) begin
      loadValid = 1'b1; loadData = 16'h0100 + 16'(i);
      @(negedge clock);
      check($sformatf("fd%0d loadReady", i), loadReady, 1);
      if (i > 0) check($sformatf("fd%0d addr", i), imemWriteAddress, i - 1);
      next_cycle();
    end
    loadValid = 1'b1; loadData = 16'hFFFF;
    @(negedge clock);
    check("fd end state", state, 0);
    check("fd end loadReady", loadReady, 0);
    check("fd end we", imemWriteEnable, 1);
    check("fd end addr", imemWriteAddress, 255);
    check("fd end data", imemWriteData, 16'h01FF);
    next_cycle();
    @(negedge clock);
    check("fd idle we", imemWriteEnable, 0);
    next_cycle();

    // Long run: counter saturates, haltRequest halts the same cycle, and a
    // start while haltRequest stays high halts immediately after CPU_RESET.
    start = 1'b1;
    cyc("sat cmd", 0, 0, 0, 0);
    cyc("sat creset", 2, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      cyc($sformatf("sat run%0d", k), 3, 1, k, (k < 15) ? k : 15);
    end
    haltRequest = 1'b1;
    cyc("hreq run", 3, 0, 20, 15);
    cyc("hreq halted", 4, 0, 20, 15);
    start = 1'b1;
    cyc("hreq start", 4, 0, 20, 15);
    cyc("hreq creset", 2, 0, 20, 15);
    cyc("hreq rerun", 3, 0, 0, 0);
    cyc("hreq rehalted", 4, 0, 0, 0);
    haltRequest = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
